// File: rtl/vga_scan_timing_if.sv
// Output bundle of the VGA scan timing generator: pixel strobe, scan position,
// active-video flags, delayed syncs and the per-frame tick for game logic.
interface vga_scan_timing_if;
  logic        pixel_en;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        blank_out;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output pixel_en, DrawX, DrawY, blank, hs, vs, blank_out, frame_start, frame_count
  );

  modport slave (
    input pixel_en, DrawX, DrawY, blank, hs, vs, blank_out, frame_start, frame_count
  );
endinterface

// File: rtl/vga_scan_timing.sv
// VGA pixel-scan timing: divided pixel strobe, DrawX/DrawY counters, syncs delayed to
// match the colour mapper pipeline, and a frame tick. Macro VGA_SCAN_FRAME_CNT_EN adds frame_count.
module vga_scan_timing #(
  parameter int CLK_DIV    = 2,
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  vga_scan_timing_if.master scan
);
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [1:0] div_q, div_d;
  logic       pixel_en_q, pixel_en_d;
  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       frame_start_q, frame_start_d;
  logic       hs_raw, vs_raw, blank_raw;

  // pixel_en is registered from the divider so it is low in reset even when CLK_DIV=1,
  // and the first strobe lands CLK_DIV cycles after Reset releases.
  always_comb begin
    div_d         = (div_q == DIV_LAST) ? 2'd0 : div_q + 2'd1;
    pixel_en_d    = (div_q == DIV_LAST);
    hc_d          = hc_q;
    vc_d          = vc_q;
    frame_start_d = 1'b0;
    if (pixel_en_q) begin
      if (hc_q == H_LAST) begin
        hc_d = 10'd0;
        if (vc_q == V_LAST) begin
          vc_d          = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          vc_d = vc_q + 10'd1;
        end
      end else begin
        hc_d = hc_q + 10'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      div_q         <= 2'd0;
      pixel_en_q    <= 1'b0;
      hc_q          <= 10'd0;
      vc_q          <= 10'd0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pixel_en_q    <= pixel_en_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign blank_raw = (hc_q < H_VIS) && (vc_q < V_VIS);
  assign hs_raw    = !((hc_q >= HS_BEGIN) && (hc_q < HS_END));
  assign vs_raw    = !((vc_q >= VS_BEGIN) && (vc_q < VS_END));

  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign scan.hs        = hs_raw;
      assign scan.vs        = vs_raw;
      assign scan.blank_out = blank_raw;
    end else begin : g_pipe
      // Each stage holds {hs, vs, blank}; reset value is the inactive pattern.
      logic [2:0] pipe_q [PIPE_DELAY];

      always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
          for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= 3'b110;
        end else if (pixel_en_q) begin
          pipe_q[0] <= {hs_raw, vs_raw, blank_raw};
          for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign scan.hs        = pipe_q[PIPE_DELAY-1][2];
      assign scan.vs        = pipe_q[PIPE_DELAY-1][1];
      assign scan.blank_out = pipe_q[PIPE_DELAY-1][0];
    end
  endgenerate

`ifdef VGA_SCAN_FRAME_CNT_EN
  logic [15:0] frame_count_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      frame_count_q <= 16'h0000;
    end else if (frame_start_d) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign scan.frame_count = frame_count_q;
`else
  assign scan.frame_count = 16'h0000;
`endif

  assign scan.pixel_en    = pixel_en_q;
  assign scan.DrawX       = hc_q;
  assign scan.DrawY       = vc_q;
  assign scan.blank       = blank_raw;
  assign scan.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: a default-timing instance for line-level checks and a
// shrunken-timing instance (CLK_DIV=3, PIPE_DELAY=2) for whole-frame behaviour.
module tb_vga_scan_timing;
  typedef struct {
    int div, pd, hv, hf, hs, hb, vv, vf, vs, vb;
  } cfg_t;

  typedef struct packed {
    logic        pe;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        bo;
    logic        fs;
    logic [15:0] fc;
  } obs_t;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_f = 1'b1;
  logic rst_s = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int k_f   = 0;
  int k_s   = 0;

  cfg_t cfg_f = '{2, 1, 640, 16, 96, 48, 480, 10, 2, 33};
  cfg_t cfg_s = '{3, 2, 16, 2, 4, 3, 12, 2, 2, 3};

  vga_scan_timing_if if_f ();
  vga_scan_timing_if if_s ();

  vga_scan_timing dut_f (
    .CLK   (clk),
    .Reset (rst_f),
    .scan  (if_f)
  );

  vga_scan_timing #(
    .CLK_DIV(3), .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .PIPE_DELAY(2)
  ) dut_s (
    .CLK   (clk),
    .Reset (rst_s),
    .scan  (if_s)
  );

  function automatic obs_t sample_f();
    return {if_f.pixel_en, if_f.DrawX, if_f.DrawY, if_f.blank, if_f.hs, if_f.vs,
            if_f.blank_out, if_f.frame_start, if_f.frame_count};
  endfunction

  function automatic obs_t sample_s();
    return {if_s.pixel_en, if_s.DrawX, if_s.DrawY, if_s.blank, if_s.hs, if_s.vs,
            if_s.blank_out, if_s.frame_start, if_s.frame_count};
  endfunction

  // ---------------- reference model ----------------
  // Everything is derived from k = clock edges since Reset released:
  // the strobe fires after edges k = D, 2D, ...; the scan position advances on the edge
  // after each strobe, so p = number of pixel advances so far.
  function automatic obs_t model(cfg_t c, int k);
    obs_t e;
    int ht, vt, p, pp, q, hx, vy;
    ht = c.hv + c.hf + c.hs + c.hb;
    vt = c.vv + c.vf + c.vs + c.vb;
    p  = (k <= 1) ? 0 : (k - 1) / c.div;
    pp = (k <= 2) ? 0 : (k - 2) / c.div;
    e.pe    = (k >= 1) && (k % c.div == 0);
    e.x     = 10'(p % ht);
    e.y     = 10'((p / ht) % vt);
    e.blank = ((p % ht) < c.hv) && (((p / ht) % vt) < c.vv);
    if (p >= c.pd) begin
      q  = p - c.pd;
      hx = q % ht;
      vy = (q / ht) % vt;
      e.hs = !(hx >= c.hv + c.hf && hx < c.hv + c.hf + c.hs);
      e.vs = !(vy >= c.vv + c.vf && vy < c.vv + c.vf + c.vs);
      e.bo = (hx < c.hv) && (vy < c.vv);
    end else begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      e.bo = 1'b0;
    end
    e.fs = (p != pp) && (p % (ht * vt) == 0);
`ifdef VGA_SCAN_FRAME_CNT_EN
    e.fc = 16'((p / (ht * vt)) % 65536);
`else
    e.fc = 16'h0000;
`endif
    return e;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    obs_t got, exp;
    rst_f = 1'b1;
    rst_s = 1'b1;
    repeat (2) @(negedge clk);
    got = sample_f();
    exp = model(cfg_f, 0);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_full got=%h exp=%h", got, exp);
    end
    got = sample_s();
    exp = model(cfg_s, 0);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_small got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_scan_full();
    obs_t got, exp;
    int first_pe = -1;
    int wrap_k   = -1;
    int wrap_y   = -1;
    rst_f = 1'b0;
    k_f   = 0;
    for (int k = 1; k <= 1700; k++) begin
      @(negedge clk);
      k_f = k;
      got = sample_f();
      exp = model(cfg_f, k);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL scan_full k=%0d got=%h exp=%h", k, got, exp);
      end
      if (got.pe && first_pe < 0) first_pe = k;
      if (wrap_k < 0 && k > 3 && got.x == 10'd0) begin
        wrap_k = k;
        wrap_y = int'(got.y);
      end
    end
    n_cmp++;
    if (first_pe != 2) begin
      n_err++;
      $display("FAIL first_pixel_en got=%0d exp=2", first_pe);
    end
    n_cmp++;
    if (wrap_k != 1601) begin
      n_err++;
      $display("FAIL line_wrap_clk got=%0d exp=1601", wrap_k);
    end
    n_cmp++;
    if (wrap_y != 1) begin
      n_err++;
      $display("FAIL line_wrap_drawy got=%0d exp=1", wrap_y);
    end
  endtask

  task automatic test_hsync_full();
    obs_t got, exp;
    logic prev_hs;
    int fall_k = -1, fall_x = -1, rise_k = -1, rise_x = -1;
    prev_hs = sample_f().hs;
    for (int n = 0; n < 2000 && rise_k < 0; n++) begin
      @(negedge clk);
      k_f++;
      got = sample_f();
      exp = model(cfg_f, k_f);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL hsync_full k=%0d got=%h exp=%h", k_f, got, exp);
      end
      if (prev_hs && !got.hs && fall_k < 0) begin
        fall_k = k_f;
        fall_x = int'(got.x);
      end
      if (!prev_hs && got.hs && fall_k >= 0) begin
        rise_k = k_f;
        rise_x = int'(got.x);
      end
      prev_hs = got.hs;
    end
    n_cmp++;
    if (fall_x != 657) begin
      n_err++;
      $display("FAIL hs_fall_drawx got=%0d exp=657", fall_x);
    end
    n_cmp++;
    if (rise_x != 753) begin
      n_err++;
      $display("FAIL hs_rise_drawx got=%0d exp=753", rise_x);
    end
    n_cmp++;
    if (rise_k - fall_k != 192 || rise_k < 0) begin
      n_err++;
      $display("FAIL hs_low_width got=%0d exp=192", rise_k - fall_k);
    end
  endtask

  task automatic test_frames_small();
    obs_t got, exp;
    int fs_k[$];
    int blank_cnt  = 0;
    int wide_pulse = 0;
    logic prev_fs = 1'b0;
    repeat ($urandom_range(1, 5)) @(negedge clk);
    rst_s = 1'b0;
    k_s   = 0;
    for (int k = 1; k <= 4275; k++) begin
      @(negedge clk);
      k_s = k;
      got = sample_s();
      exp = model(cfg_s, k);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL frames_small k=%0d got=%h exp=%h", k, got, exp);
      end
      if (got.fs) begin
        if (prev_fs) wide_pulse++;
        else fs_k.push_back(k);
      end
      if (fs_k.size() == 1 && got.pe && got.blank) blank_cnt++;
      prev_fs = got.fs;
    end
    n_cmp++;
    if (fs_k.size() != 2) begin
      n_err++;
      $display("FAIL frame_start_count got=%0d exp=2", fs_k.size());
    end
    n_cmp++;
    if (fs_k.size() < 1 || fs_k[0] != 1426) begin
      n_err++;
      $display("FAIL frame_start_first got=%0d exp=1426", (fs_k.size() > 0) ? fs_k[0] : -1);
    end
    n_cmp++;
    if (fs_k.size() < 2 || fs_k[1] - fs_k[0] != 1425) begin
      n_err++;
      $display("FAIL frame_start_spacing got=%0d exp=1425",
               (fs_k.size() > 1) ? fs_k[1] - fs_k[0] : -1);
    end
    n_cmp++;
    if (wide_pulse != 0) begin
      n_err++;
      $display("FAIL frame_start_width got=%0d extra-high cycles exp=0", wide_pulse);
    end
    n_cmp++;
    if (blank_cnt != 192) begin
      n_err++;
      $display("FAIL visible_ticks got=%0d exp=192", blank_cnt);
    end
  endtask

  task automatic test_mid_reset();
    obs_t got, exp;
    int tx, ty;
    bit found = 0;
    tx = $urandom_range(1, 24);
    ty = $urandom_range(1, 18);
    for (int n = 0; n < 3 * 1425 && !found; n++) begin
      @(negedge clk);
      k_s++;
      got = sample_s();
      exp = model(cfg_s, k_s);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL mid_reset_run k=%0d got=%h exp=%h", k_s, got, exp);
      end
      if (int'(got.x) == tx && int'(got.y) == ty) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_reset_target got=not_reached exp=x%0d_y%0d", tx, ty);
    end
    @(posedge clk);
    #($urandom_range(1, 3));
    rst_s = 1'b1;
    #1;
    got = sample_s();
    exp = model(cfg_s, 0);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL mid_reset_async got=%h exp=%h", got, exp);
    end
    repeat (3) begin
      @(negedge clk);
      got = sample_s();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL mid_reset_hold got=%h exp=%h", got, exp);
      end
    end
    rst_s = 1'b0;
    k_s   = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      k_s = k;
      got = sample_s();
      exp = model(cfg_s, k);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL mid_reset_resume k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_frame_count();
    obs_t got, exp;
    logic [15:0] exp_fc;
`ifdef VGA_SCAN_FRAME_CNT_EN
    exp_fc = 16'd3;
`else
    exp_fc = 16'd0;
`endif
    while (k_s < 4276) begin
      @(negedge clk);
      k_s++;
      got = sample_s();
      exp = model(cfg_s, k_s);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL frame_count_run k=%0d got=%h exp=%h", k_s, got, exp);
      end
    end
    n_cmp++;
    if (got.fc !== exp_fc || got.fs !== 1'b1) begin
      n_err++;
      $display("FAIL frame_count_end got fc=%0d fs=%b exp fc=%0d fs=1", got.fc, got.fs, exp_fc);
    end
  endtask

  initial begin
    test_reset();
    test_scan_full();
    test_hsync_full();
    test_frames_small();
    test_mid_reset();
    test_frame_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
